uart_tx: RTL

Serial UART transmitter: the transmit half of the UART module, the counterpart of `UART_RX`. It accepts parallel bytes over a valid/ready handshake and serialises each one onto `Tx` as start bit, data bits LSB first, then stop bit(s). A one-entry holding register lets a second byte be queued while a frame is in flight, so consecutive frames go out with no idle gap. Bit timing matches `UART_RX`: one bit lasts `CLKS_PER_BIT` `sys_clk` cycles, default 16.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_tx.sv | 122 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive halves.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
    localparam logic        IDLE_LEVEL           = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel byte handshake into the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 data_valid;
    logic                 tx_ready;

    modport master (output data_in, output data_valid, input  tx_ready);
    modport slave  (input  data_in, input  data_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: bit_tick marks the last cycle of a bit, bit_pre_tick the cycle before it.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick,
    output logic bit_pre_tick
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] baud_cnt;

    assign bit_tick     = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign bit_pre_tick = (baud_cnt == CW'(CLKS_PER_BIT - 2));

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (clear || bit_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/stop serialiser.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic     sys_clk,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     tx_busy,
    output logic     tx_done,
    output logic     Tx
);
    localparam int unsigned BW = $clog2(DATA_BITS);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_empty;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 bit_tick;
    logic                 bit_pre_tick;
    logic                 last_stop;

    // Counter is held at zero in IDLE so START always begins a full bit period.
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .clear        (state == ST_IDLE),
        .bit_tick     (bit_tick),
        .bit_pre_tick (bit_pre_tick)
    );

    assign last_stop    = (stop_idx == 1'(STOP_BITS - 1));
    assign bus.tx_ready = hold_empty;
    assign tx_busy      = busy_r;
    assign tx_done      = done_r;
    assign Tx           = tx_r;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift      <= '0;
            hold       <= '0;
            hold_empty <= 1'b1;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            tx_r       <= IDLE_LEVEL;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // Accept and drain never coincide: draining needs the register full.
            if (bus.data_valid && hold_empty) begin
                hold       <= bus.data_in;
                hold_empty <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!hold_empty) begin
                        shift      <= hold;
                        hold_empty <= 1'b1;
                        state      <= ST_START;
                        tx_r       <= ~IDLE_LEVEL;
                        busy_r     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        state   <= ST_DATA;
                        tx_r    <= shift[0];
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            state    <= ST_STOP;
                            tx_r     <= IDLE_LEVEL;
                            bit_idx  <= '0;
                            stop_idx <= 1'b0;
                        end else begin
                            shift   <= shift >> 1;
                            tx_r    <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    // Registered pulse lands on the final stop cycle.
                    if (bit_pre_tick && last_stop) begin
                        done_r <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (!last_stop) begin
                            stop_idx <= stop_idx + 1'b1;
                        end else if (!hold_empty) begin
                            shift      <= hold;
                            hold_empty <= 1'b1;
                            state      <= ST_START;
                            tx_r       <= ~IDLE_LEVEL;
                            stop_idx   <= 1'b0;
                        end else begin
                            state    <= ST_IDLE;
                            busy_r   <= 1'b0;
                            stop_idx <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
